// File: rtl/clock_gate_sequencer_if.sv
// rtl/clock_gate_sequencer_if.sv - configuration request handshake for the clock gate sequencer
interface clock_gate_sequencer_if #(
  parameter int MAX_MULTIPLIER = 4
);
  localparam int MULT_W = $clog2(MAX_MULTIPLIER + 1);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [MULT_W-1:0] cfg_multiplier;
  logic              cfg_enable;
  logic              cfg_error;

  modport master (
    output cfg_valid, cfg_multiplier, cfg_enable,
    input  cfg_ready, cfg_error
  );

  modport slave (
    input  cfg_valid, cfg_multiplier, cfg_enable,
    output cfg_ready, cfg_error
  );
endinterface

// File: rtl/clock_gate_sequencer.sv
// rtl/clock_gate_sequencer.sv - glitch-safe reconfiguration and idle auto-gating for a clock gating cell
module clock_gate_sequencer #(
  parameter int MAX_MULTIPLIER   = 4,
  parameter int DRAIN_CYCLES     = 2,
  parameter int SETTLE_CYCLES    = 4,
  parameter int IDLE_TIMEOUT     = 16,
  parameter int RESET_MULTIPLIER = 1,
  localparam int MULT_W          = $clog2(MAX_MULTIPLIER + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst,
  clock_gate_sequencer_if.slave  cfg,
  input  logic                   activity,
  output logic                   gate_enable,
  output logic [MULT_W-1:0]      gate_multiplier,
  output logic                   busy,
  output logic                   auto_gated
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_LOAD, S_SETTLE} state_t;

  localparam int SEQ_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int IDLE_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [MULT_W-1:0] MAX_M       = MULT_W'(MAX_MULTIPLIER);
  localparam logic [MULT_W-1:0] RESET_M     = MULT_W'(RESET_MULTIPLIER);
  localparam logic [SEQ_W-1:0]  DRAIN_LAST  = SEQ_W'(DRAIN_CYCLES - 1);
  localparam logic [SEQ_W-1:0]  SETTLE_LAST = SEQ_W'(SETTLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(IDLE_TIMEOUT);

  state_t            state, state_nx;
  logic [SEQ_W-1:0]  seq_cnt, seq_cnt_nx;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nx;
  logic [MULT_W-1:0] lat_mult, lat_mult_nx;
  logic [MULT_W-1:0] gate_multiplier_nx;
  logic              lat_en, lat_en_nx;
  logic              sw_enable, sw_enable_nx;
  logic              gate_enable_nx, busy_nx, cfg_error_nx, auto_gated_nx;
  logic              accept, legal, reconfig, drain_done, settle_done;

  assign cfg.cfg_ready = (state == S_IDLE) && !rst;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign legal         = (cfg.cfg_multiplier != '0) && (cfg.cfg_multiplier <= MAX_M);
  assign reconfig      = accept && legal && (cfg.cfg_multiplier != gate_multiplier);
  assign drain_done    = (seq_cnt == DRAIN_LAST);
  assign settle_done   = (seq_cnt == SETTLE_LAST);

  // State register; a reset drops any sequence in flight.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Sequence: only a legal request for a new multiplier leaves IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (reconfig)    state_nx = S_DRAIN;
      S_DRAIN:  if (drain_done)  state_nx = S_LOAD;
      S_LOAD:                    state_nx = S_SETTLE;
      S_SETTLE: if (settle_done) state_nx = S_IDLE;
      default:                   state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and the latched request.
  always_comb begin
    seq_cnt_nx         = seq_cnt;
    idle_cnt_nx        = idle_cnt;
    lat_mult_nx        = lat_mult;
    lat_en_nx          = lat_en;
    sw_enable_nx       = sw_enable;
    gate_enable_nx     = gate_enable;
    gate_multiplier_nx = gate_multiplier;
    busy_nx            = busy;
    auto_gated_nx      = auto_gated;
    cfg_error_nx       = 1'b0;
    case (state)
      S_IDLE: begin
        seq_cnt_nx = '0;
        if (reconfig) begin
          // Accept wins over a coinciding timeout or wake.
          lat_mult_nx    = cfg.cfg_multiplier;
          lat_en_nx      = cfg.cfg_enable;
          busy_nx        = 1'b1;
          gate_enable_nx = 1'b0;
          auto_gated_nx  = 1'b0;
          idle_cnt_nx    = '0;
        end else if (accept && legal) begin
          // Same multiplier: no need to drain, just apply the enable.
          sw_enable_nx   = cfg.cfg_enable;
          gate_enable_nx = cfg.cfg_enable;
          auto_gated_nx  = 1'b0;
          idle_cnt_nx    = '0;
        end else begin
          if (accept) cfg_error_nx = 1'b1;
          if (IDLE_TIMEOUT > 0) begin
            if (activity || !sw_enable) begin
              idle_cnt_nx = '0;
              if (auto_gated && activity) begin
                auto_gated_nx  = 1'b0;
                gate_enable_nx = sw_enable;
              end
            end else if (idle_cnt != IDLE_MAX) begin
              idle_cnt_nx = idle_cnt + 1'b1;
              if (idle_cnt == IDLE_LAST && !auto_gated) begin
                auto_gated_nx  = 1'b1;
                gate_enable_nx = 1'b0;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        idle_cnt_nx = '0;
        seq_cnt_nx  = drain_done ? '0 : seq_cnt + 1'b1;
      end
      S_LOAD: begin
        // Gate is already off here, so the multiplier can change safely.
        idle_cnt_nx        = '0;
        seq_cnt_nx         = '0;
        gate_multiplier_nx = lat_mult;
      end
      S_SETTLE: begin
        idle_cnt_nx = '0;
        if (settle_done) begin
          seq_cnt_nx     = '0;
          busy_nx        = 1'b0;
          sw_enable_nx   = lat_en;
          gate_enable_nx = lat_en;
          auto_gated_nx  = 1'b0;
        end else begin
          seq_cnt_nx = seq_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      seq_cnt         <= '0;
      idle_cnt        <= '0;
      lat_mult        <= RESET_M;
      lat_en          <= 1'b0;
      sw_enable       <= 1'b0;
      gate_enable     <= 1'b0;
      gate_multiplier <= RESET_M;
      busy            <= 1'b0;
      auto_gated      <= 1'b0;
      cfg.cfg_error   <= 1'b0;
    end else begin
      seq_cnt         <= seq_cnt_nx;
      idle_cnt        <= idle_cnt_nx;
      lat_mult        <= lat_mult_nx;
      lat_en          <= lat_en_nx;
      sw_enable       <= sw_enable_nx;
      gate_enable     <= gate_enable_nx;
      gate_multiplier <= gate_multiplier_nx;
      busy            <= busy_nx;
      auto_gated      <= auto_gated_nx;
      cfg.cfg_error   <= cfg_error_nx;
    end
  end

endmodule

// File: tb/tb_clock_gate_sequencer.sv
// tb/tb_clock_gate_sequencer.sv - scoreboard bench for clock_gate_sequencer
module tb_clock_gate_sequencer;
  localparam int MAXM = 4;
  localparam int MW   = $clog2(MAXM + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst2 = 1'b1;
  logic          activity = 1'b0;
  logic          activity2 = 1'b0;
  logic          ge, busy, ag, ge2, busy2, ag2;
  logic [MW-1:0] gm, gm2;
  logic          ag2_seen = 1'b0;

  clock_gate_sequencer_if #(.MAX_MULTIPLIER(MAXM)) cfg1 ();
  clock_gate_sequencer_if #(.MAX_MULTIPLIER(MAXM)) cfg2 ();

  clock_gate_sequencer #(
    .MAX_MULTIPLIER(MAXM), .DRAIN_CYCLES(2), .SETTLE_CYCLES(4),
    .IDLE_TIMEOUT(16), .RESET_MULTIPLIER(1)
  ) dut (
    .clk_in(clk), .rst(rst), .cfg(cfg1), .activity(activity),
    .gate_enable(ge), .gate_multiplier(gm), .busy(busy), .auto_gated(ag)
  );

  clock_gate_sequencer #(
    .MAX_MULTIPLIER(MAXM), .DRAIN_CYCLES(2), .SETTLE_CYCLES(4),
    .IDLE_TIMEOUT(0), .RESET_MULTIPLIER(1)
  ) dut_noto (
    .clk_in(clk), .rst(rst2), .cfg(cfg2), .activity(activity2),
    .gate_enable(ge2), .gate_multiplier(gm2), .busy(busy2), .auto_gated(ag2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    string tag;
    int    ge;
    int    gm;
    int    busy;
    int    err;
    int    ag;
    int    rdy;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input string field, input int act, input int want);
    if (want >= 0) begin
      vectors++;
      if (act != want) begin
        miscompares++;
        $display("FAIL %s.%s: got %0d, expected %0d (cycle %0d)", tag, field, act, want, cyc);
      end
    end
  endtask

  task automatic push(input int at, input string tag, input int ge_, input int gm_,
                      input int busy_, input int err_, input int ag_, input int rdy_);
    exp_t e;
    e.at = at; e.tag = tag; e.ge = ge_; e.gm = gm_;
    e.busy = busy_; e.err = err_; e.ag = ag_; e.rdy = rdy_;
    sb.push_back(e);
  endtask

  // Monitor: every expectation due this cycle is compared away from the clock edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) chk(e.tag, "cycle", cyc, e.at);
      chk(e.tag, "gate_enable",     int'(ge),             e.ge);
      chk(e.tag, "gate_multiplier", int'(gm),             e.gm);
      chk(e.tag, "busy",            int'(busy),           e.busy);
      chk(e.tag, "cfg_error",       int'(cfg1.cfg_error), e.err);
      chk(e.tag, "auto_gated",      int'(ag),             e.ag);
      chk(e.tag, "cfg_ready",       int'(cfg1.cfg_ready), e.rdy);
    end
    if (ag2) ag2_seen <= 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input bit en, output int e0);
    cfg1.cfg_valid      = 1'b1;
    cfg1.cfg_multiplier = MW'(m);
    cfg1.cfg_enable     = en;
    tick(1);
    cfg1.cfg_valid = 1'b0;
    e0 = cyc;
  endtask

  initial begin
    int e0;
    int n;
    cfg1.cfg_valid = 1'b0; cfg1.cfg_multiplier = '0; cfg1.cfg_enable = 1'b0;
    cfg2.cfg_valid = 1'b0; cfg2.cfg_multiplier = '0; cfg2.cfg_enable = 1'b0;

    tick(2);
    push(cyc, "reset", 0, 1, 0, 0, 0, 0);
    tick(1);
    rst = 1'b0; rst2 = 1'b0;
    push(cyc, "reset_release", 0, 1, 0, 0, 0, 1);
    tick(1);

    activity = 1'b1;
    cfg2.cfg_valid = 1'b1; cfg2.cfg_multiplier = MW'(1); cfg2.cfg_enable = 1'b1;
    req(1, 1'b1, e0);
    cfg2.cfg_valid = 1'b0;
    push(e0, "fast_enable", 1, 1, 0, 0, 0, 1);
    tick(1);

    req(3, 1'b1, e0);
    push(e0, "rs_drain", 0, 1, 1, 0, 0, 0);
    push(e0 + 3, "rs_settle", 0, 3, 1, 0, 0, 0);
    tick(4);
    rst = 1'b1;
    push(cyc, "rs_reset", 0, 1, 0, 0, 0, 0);
    tick(1);
    rst = 1'b0;
    push(cyc, "rs_release", 0, 1, 0, 0, 0, 1);
    tick(8);
    push(cyc, "rs_no_partial", 0, 1, 0, 0, 0, 1);
    tick(1);

    req(1, 1'b1, e0);
    push(e0, "reenable", 1, 1, 0, 0, 0, 1);
    tick(1);

    req(3, 1'b1, e0);
    push(e0, "rc_start", 0, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) push(e0 + k, "rc_seq", 0, (k >= 3) ? 3 : 1, 1, 0, 0, 0);
    push(e0 + 7, "rc_done", 1, 3, 0, 0, 0, 1);
    tick(8);

    req(3, 1'b0, e0);
    push(e0, "fast_off", 0, 3, 0, 0, 0, 1);
    push(e0 + 1, "fast_off_hold", 0, 3, 0, 0, 0, 1);
    tick(2);
    req(3, 1'b1, e0);
    push(e0, "fast_on", 1, 3, 0, 0, 0, 1);
    tick(1);

    req(0, 1'b1, e0);
    push(e0, "illegal0", 1, 3, 0, 1, 0, 1);
    push(e0 + 1, "illegal0_end", 1, 3, 0, 0, 0, 1);
    tick(1);
    req(5, 1'b1, e0);
    push(e0, "illegal5", 1, 3, 0, 1, 0, 1);
    push(e0 + 1, "illegal5_end", 1, 3, 0, 0, 0, 1);
    tick(1);

    req(2, 1'b1, e0);
    cfg1.cfg_valid = 1'b1; cfg1.cfg_multiplier = MW'(4); cfg1.cfg_enable = 1'b1;
    for (int k = 0; k <= 6; k++) push(e0 + k, "bp_wait", 0, -1, 1, 0, 0, 0);
    push(e0 + 7,  "bp_ready",  1, 2, 0, 0, 0, 1);
    push(e0 + 8,  "bp_accept", 0, 2, 1, 0, 0, 0);
    push(e0 + 11, "bp_load",   0, 4, 1, 0, 0, 0);
    push(e0 + 15, "bp_done",   1, 4, 0, 0, 0, 1);
    push(e0 + 16, "bp_once",   1, 4, 0, 0, 0, 1);
    tick(8);
    cfg1.cfg_valid = 1'b0;
    tick(9);

    n = cyc;
    activity = 1'b0;
    push(n + 15, "ag_before",  1, 4, 0, 0, 0, 1);
    push(n + 16, "ag_trigger", 0, 4, 0, 0, 1, 1);
    tick(18);
    push(n + 18, "ag_hold", 0, 4, 0, 0, 1, 1);
    activity = 1'b1;
    tick(1);
    push(n + 19, "ag_wake", 1, 4, 0, 0, 0, 1);
    tick(1);

    n = cyc;
    activity = 1'b0;
    push(n + 15, "col_pre", 1, 4, 0, 0, 0, 1);
    tick(15);
    activity = 1'b1;
    cfg1.cfg_valid = 1'b1; cfg1.cfg_multiplier = MW'(1); cfg1.cfg_enable = 1'b1;
    tick(1);
    cfg1.cfg_valid = 1'b0;
    push(n + 16, "col_e0", 0, 4, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) push(n + 16 + k, "col_seq", 0, (k >= 3) ? 1 : 4, 1, 0, 0, 0);
    push(n + 23, "col_done", 1, 1, 0, 0, 0, 1);
    tick(10);

    chk("scoreboard", "pending", sb.size(), 0);
    chk("no_timeout", "auto_gated_seen", int'(ag2_seen), 0);
    chk("no_timeout", "gate_enable", int'(ge2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clock_gate_sequencer.md
Name: clock_gate_sequencer

Overview:
- Control front-end for ConfigurableClockGating. Drives its enable and multiplier inputs.
- Accepts reconfiguration requests over a valid/ready handshake and applies them glitch-safely: drain (gate off) -> load multiplier -> settle -> resume.
- Auto-gates the clock after a programmable idle period.
- Sits between the power/clock management logic and the gating cell.

Parameters:
- MAX_MULTIPLIER, 4, largest legal multiplier; must match the gating cell instance.
- DRAIN_CYCLES, 2, cycles the gate is held off before the multiplier changes (>=1).
- SETTLE_CYCLES, 4, cycles the gate is held off after the multiplier changes (>=1).
- IDLE_TIMEOUT, 16, consecutive idle cycles before auto-gating; 0 disables auto-gating.
- RESET_MULTIPLIER, 1, multiplier value driven during and after reset (1..MAX_MULTIPLIER).

Ports:
- clk_in  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  configuration request valid.
- cfg_ready  output  1  block can accept a request.
- cfg_multiplier  input  MULT_W  requested multiplier.
- cfg_enable  input  1  requested gate enable once the request is applied.
- activity  input  1  downstream activity indication; resets the idle timer.
- gate_enable  output  1  to the gating cell enable.
- gate_multiplier  output  MULT_W  to the gating cell multiplier.
- busy  output  1  reconfiguration in progress.
- cfg_error  output  1  one-cycle pulse: rejected (illegal) request.
- auto_gated  output  1  clock currently gated by the idle timer.

Behaviour:
- Width: MULT_W = $clog2(MAX_MULTIPLIER+1), a localparam, so MAX_MULTIPLIER itself is representable.
- Register types: all outputs are flops except cfg_ready, which is a decode of state.
- cfg_ready: 1 only when state == IDLE and rst is low.
- Reset values, applied immediately on rst assertion: state IDLE, gate_enable 0, gate_multiplier RESET_MULTIPLIER, busy 0, cfg_error 0, auto_gated 0, sw_enable 0, counters 0.
- Reset mid-sequence: the pending request is dropped. No partial update survives.
- Handshake: a transfer occurs at an edge where cfg_valid && cfg_ready. Timings below are measured from that edge, E0, and give register values after edge En.
- Illegal request (cfg_multiplier == 0 or > MAX_MULTIPLIER):
  - After E0: cfg_error = 1 for exactly one cycle.
  - No other state changes; the block stays in IDLE.
- Fast path (legal, cfg_multiplier == gate_multiplier):
  - After E0: sw_enable = cfg_enable, auto_gated = 0, idle counter = 0, gate_enable = cfg_enable.
  - The block stays in IDLE.
- Full sequence (legal, cfg_multiplier differs from gate_multiplier): the request values are latched at E0.
  - DRAIN: entered after E0, busy = 1, gate_enable = 0. Lasts DRAIN_CYCLES cycles.
  - LOAD: entered after E(DRAIN_CYCLES). Lasts one cycle.
  - SETTLE: entered after E(DRAIN_CYCLES+1), with gate_multiplier = latched value. Lasts SETTLE_CYCLES cycles, gate_enable = 0.
  - IDLE: entered after E(DRAIN_CYCLES+1+SETTLE_CYCLES), with busy = 0, sw_enable = latched cfg_enable, gate_enable = latched cfg_enable, auto_gated = 0.
- gate_multiplier changes only on the LOAD->SETTLE edge, and only while gate_enable is 0.
- Requests arriving while not ready are held off by cfg_ready = 0 and are never dropped.
- Auto-gate timer (active only when IDLE_TIMEOUT > 0):
  - Counts only in IDLE with sw_enable = 1 and activity = 0. Saturates.
  - Cleared by activity = 1, by leaving IDLE, or by sw_enable = 0. Held at 0 during DRAIN, LOAD and SETTLE.
  - Trigger: on the edge that completes IDLE_TIMEOUT consecutive idle cycles, auto_gated = 1 and gate_enable = 0.
  - Wake: activity = 1 while auto_gated is set gives auto_gated = 0 and gate_enable = sw_enable on the next edge (1-cycle wake latency).
- Simultaneous events:
  - A request accept and activity in the same cycle: the request takes priority and auto_gated is cleared.
  - An accept on the same edge as the timeout: the accept wins and the timer is not triggered.
- In IDLE, gate_enable always equals sw_enable && !auto_gated.

Test Plan:
- Reset: assert rst mid-SETTLE (multiplier 1 -> 3) -> immediately gate_enable = 0, gate_multiplier = 1, busy = 0. After release, cfg_ready = 1.
- Reconfig with defaults: from IDLE (mult 1, enabled), request mult = 3, enable = 1 -> gate_enable = 0 after E0, gate_multiplier = 3 after E3, gate_enable = 1 and cfg_ready = 1 after E7. busy is high for 7 cycles.
- Fast path and illegal requests:
  - Request mult = 3 while already at 3, enable = 0 -> gate_enable = 0 after E0, busy stays 0.
  - Request mult = 0, then mult = 5 -> cfg_error pulses one cycle each, gate_multiplier unchanged.
- Back-pressure: hold cfg_valid with mult 2 -> 4 during an active sequence -> cfg_ready = 0 until IDLE. Then accepted exactly once, and the final gate_multiplier = 4.
- Auto-gate: enabled, activity = 0 for 16 cycles -> auto_gated = 1, gate_enable = 0 on the 16th edge. activity = 1 -> both restored on the next edge. With IDLE_TIMEOUT = 0, the bench never sees auto_gated.
- Collision: activity and request accept on the timeout edge -> the sequence starts, auto_gated stays 0, and there is no spurious gate_enable pulse.
